// File: rtl/acumulador_somador4.sv
// Accumulating controller wrapped around an external combinational ripple adder:
// feeds A/B/Cin, captures S/Cout/C3, and folds N_OPS operands into one registered sum.
module acumulador_somador4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_OPS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_sub,
  output logic [WIDTH-1:0] o_add_a,
  output logic [WIDTH-1:0] o_add_b_c,
  output logic             o_add_cin_c,
  input  logic [WIDTH-1:0] i_add_s,
  input  logic             i_add_cout,
  input  logic             i_add_c3,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_flag,
  output logic             o_overflow_flag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_busy
);

  // Wide enough to hold N_OPS itself, so the counter never wraps mid-run.
  localparam int unsigned CNT_W = $clog2(N_OPS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   w_result_nxt;
  logic               r_carry;
  logic               w_carry_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic               w_accept;

  // Adder operand path; subtraction is A + ~B + 1.
  assign o_add_a     = r_result;
  assign o_add_b_c   = i_in_sub ? ~i_in_data : i_in_data;
  assign o_add_cin_c = i_in_sub;

  assign w_accept = i_in_valid & r_in_ready;

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_carry_nxt  = r_carry;
    w_ovf_nxt    = r_ovf;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_result_nxt = '0;
          w_carry_nxt  = 1'b0;
          w_ovf_nxt    = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_accept) begin
          w_result_nxt = i_add_s;
          // Borrow on subtract is the absence of carry-out.
          w_carry_nxt  = r_carry | (i_in_sub ? ~i_add_cout : i_add_cout);
          w_ovf_nxt    = r_ovf | (i_add_cout ^ i_add_c3);
          w_cnt_nxt    = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(N_OPS - 1)) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and handshake registers; handshakes follow the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_result    <= w_result_nxt;
      r_carry     <= w_carry_nxt;
      r_ovf       <= w_ovf_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt == ST_ACCUM);
      r_out_valid <= (w_state_nxt == ST_DONE);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_in_ready      = r_in_ready;
  assign o_out_valid     = r_out_valid;
  assign o_busy          = r_busy;
  assign o_result        = r_result;
  assign o_carry_flag    = r_carry;
  assign o_overflow_flag = r_ovf;

endmodule

// File: tb/tb_acumulador_somador4.sv
// Directed bench for acumulador_somador4 with a behavioural 4-bit ripple adder attached.
module tb_acumulador_somador4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_sub;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_s;
  logic       add_cout;
  logic       add_c3;
  logic [3:0] result;
  logic       carry_flag;
  logic       overflow_flag;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Adder model: full sum plus carry into the MSB.
  logic [4:0] w_sum;
  logic [3:0] w_low;
  assign w_sum    = {1'b0, add_a} + {1'b0, add_b} + 5'(add_cin);
  assign w_low    = {1'b0, add_a[2:0]} + {1'b0, add_b[2:0]} + 4'(add_cin);
  assign add_s    = w_sum[3:0];
  assign add_cout = w_sum[4];
  assign add_c3   = w_low[3];

  acumulador_somador4 #(.WIDTH(4), .N_OPS(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_sub(in_sub),
    .o_add_a(add_a), .o_add_b_c(add_b), .o_add_cin_c(add_cin),
    .i_add_s(add_s), .i_add_cout(add_cout), .i_add_c3(add_c3),
    .o_result(result), .o_carry_flag(carry_flag), .o_overflow_flag(overflow_flag),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Snapshot of all registered outputs: {result, carry, ovf, in_ready, out_valid, busy}.
  function automatic logic [8:0] snap();
    return {result, carry_flag, overflow_flag, in_ready, out_valid, busy};
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 8'(busy), 8'd1);
    chk("start_in_ready", 8'(in_ready), 8'd1);
    chk("start_result", 8'(result), 8'h0);
  endtask

  task automatic push(input logic [3:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_final(input string tag, input logic [3:0] r, input logic c, input logic o);
    chk({tag, "_valid"}, 8'(out_valid), 8'd1);
    chk({tag, "_result"}, 8'(result), 8'(r));
    chk({tag, "_carry"}, 8'(carry_flag), 8'(c));
    chk({tag, "_ovf"}, 8'(overflow_flag), 8'(o));
    chk({tag, "_in_ready"}, 8'(in_ready), 8'd0);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 8'(out_valid), 8'd0);
    chk({tag, "_drain_busy"}, 8'(busy), 8'd0);
  endtask

  task automatic run_test2(input string tag);
    do_start();
    push(4'h1, 1'b0);
    chk({tag, "_acc1"}, 8'(result), 8'h1);
    push(4'h2, 1'b0);
    push(4'h3, 1'b0);
    chk({tag, "_acc3"}, 8'(result), 8'h6);
    chk({tag, "_add_a"}, 8'(add_a), 8'h6);
    chk({tag, "_not_yet_valid"}, 8'(out_valid), 8'd0);
    push(4'h4, 1'b0);
    check_final(tag, 4'hA, 1'b0, 1'b1);
    drain(tag);
  endtask

  logic [8:0] held;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'h0; in_sub = 1'b0; out_ready = 1'b0;

    // 1: reset
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_result", 8'(result), 8'h0);
    chk("rst_carry", 8'(carry_flag), 8'd0);
    chk("rst_ovf", 8'(overflow_flag), 8'd0);
    chk("rst_in_ready", 8'(in_ready), 8'd0);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_add_a", 8'(add_a), 8'h0);

    // operand in IDLE must be ignored
    in_valid = 1'b1; in_data = 4'h7;
    tick();
    in_valid = 1'b0;
    chk("idle_ignore", 8'(result), 8'h0);

    // 2: 1+2+3+4
    run_test2("t2");

    // 3: F+1 wraps
    do_start();
    push(4'hF, 1'b0);
    push(4'h1, 1'b0);
    chk("t3_wrap", 8'(result), 8'h0);
    chk("t3_carry_mid", 8'(carry_flag), 8'd1);
    push(4'h0, 1'b0);
    push(4'h0, 1'b0);
    check_final("t3", 4'h0, 1'b1, 1'b0);
    drain("t3");

    // 4: +5 -3 -4 +0
    do_start();
    push(4'h5, 1'b0);
    in_data = 4'h3; in_sub = 1'b1;
    #1;
    chk("t4_add_b", 8'(add_b), 8'hC);
    chk("t4_add_cin", 8'(add_cin), 8'd1);
    chk("t4_add_a", 8'(add_a), 8'h5);
    push(4'h3, 1'b1);
    chk("t4_acc2", 8'(result), 8'h2);
    chk("t4_no_borrow", 8'(carry_flag), 8'd0);
    push(4'h4, 1'b1);
    chk("t4_acc3", 8'(result), 8'hE);
    chk("t4_borrow", 8'(carry_flag), 8'd1);
    push(4'h0, 1'b0);
    check_final("t4", 4'hE, 1'b1, 1'b0);
    drain("t4");

    // 5: gaps, held DONE, start in DONE
    do_start();
    push(4'h7, 1'b0);
    tick();
    tick();
    chk("t5_gap_hold", 8'(result), 8'h7);
    push(4'h1, 1'b0);
    chk("t5_ovf_mid", 8'(overflow_flag), 8'd1);
    tick();
    tick();
    push(4'h0, 1'b0);
    tick();
    tick();
    chk("t5_gap_busy", 8'(busy), 8'd1);
    chk("t5_gap_not_valid", 8'(out_valid), 8'd0);
    push(4'h0, 1'b0);
    check_final("t5", 4'h8, 1'b0, 1'b1);
    held = snap();
    in_valid = 1'b1; in_data = 4'h3;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      tick();
      chk("t5_done_hold", 8'(snap()), 8'(held));
    end
    in_valid = 1'b0;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    chk("t5_idle_valid", 8'(out_valid), 8'd0);
    chk("t5_idle_busy", 8'(busy), 8'd0);
    chk("t5_idle_ready", 8'(in_ready), 8'd0);
    tick();
    chk("t5_no_restart", 8'(busy), 8'd0);
    chk("t5_result_kept", 8'(result), 8'h8);

    // 6: reset mid-accumulation
    do_start();
    push(4'h3, 1'b0);
    push(4'h3, 1'b0);
    chk("t6_partial", 8'(result), 8'h6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_result", 8'(result), 8'h0);
    chk("t6_rst_busy", 8'(busy), 8'd0);
    chk("t6_rst_flags", 8'({carry_flag, overflow_flag}), 8'd0);
    chk("t6_rst_in_ready", 8'(in_ready), 8'd0);
    run_test2("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
